axi_wr_beat_sequencer: RTL and testbench
========================================

AXI_WR_BEAT_SEQUENCER -- requirements
Module: axi_wr_beat_sequencer

Interface
REQ-001 SHALL have parameters: TIDW, default 1, AXI ID width; AW, default 32, address width; DW, default 64, data width (8..1024, power of 2); LENW, default 8, burst-length width.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk, input, 1, sole clock; all logic on posedge
- rst, input, 1, synchronous active-high reset
- axi_aw_id, input, TIDW, AWID
- axi_aw_addr, input, AW, AWADDR
- axi_aw_len, input, LENW, AWLEN (beats-1)
- axi_aw_size, input, 3, AWSIZE
- axi_aw_burst, input, 2, AWBURST (00 FIXED, 01 INCR)
- axi_aw_valid, input, 1, AWVALID
- axi_aw_ready, output, 1, AWREADY
- axi_w_data, input, DW, WDATA
- axi_w_strb, input, DW/8, WSTRB
- axi_w_last, input, 1, WLAST
- axi_w_valid, input, 1, WVALID
- axi_w_ready, output, 1, WREADY
- cmd_addr, output, AW, per-beat byte address to AHB side
- cmd_size, output, 3, per-beat size
- cmd_data, output, DW, beat data
- cmd_strb, output, DW/8, beat strobes
- cmd_first, output, 1, first beat of burst (AHB NONSEQ)
- cmd_valid, output, 1, beat command valid
- cmd_ready, input, 1, AHB side accepts beat
- axi_b_id, output, TIDW, BID
- axi_b_resp, output, 2, BRESP
- axi_b_valid, output, 1, BVALID
- axi_b_ready, input, 1, BREADY
- err_sticky, output, 1, sticky protocol-error flag

Function
REQ-003 SHALL implement FSM IDLE -> BEAT -> RESP -> IDLE; one burst outstanding.
REQ-004 axi_aw_ready SHALL be 1 only in IDLE; AW handshake latches id, addr, len, size, burst; next state BEAT.
REQ-005 In BEAT: cmd_valid = axi_w_valid, axi_w_ready = cmd_ready, cmd_data/strb pass through combinationally (zero latency); elsewhere both 0.
REQ-006 Beat handshake SHALL be axi_w_valid && cmd_ready in BEAT; beat counter increments by 1 per handshake.
REQ-007 cmd_addr for beat 0 SHALL equal latched AWADDR unmodified; cmd_first = 1 only for beat 0.
REQ-008 Beat n+1 address SHALL be (addr_n & ~(2^size-1)) + 2^size for INCR; addr_n for FIXED; modulo 2^AW (wraps to 0, no error).
REQ-009 Reserved burst (10, 11) SHALL be handled as INCR and set response SLVERR.
REQ-010 size > log2(DW/8) SHALL set response SLVERR; beats still consumed and forwarded with cmd_size clamped to log2(DW/8).
REQ-011 After handshake of beat len (counter == latched len), FSM SHALL enter RESP next cycle.
REQ-012 In RESP: axi_b_valid = 1, axi_b_id = latched id, axi_b_resp = OKAY (00) or SLVERR (10); stay until axi_b_ready; then IDLE (AW accepted no earlier than the following cycle).
REQ-013 len = 0 SHALL produce exactly one beat with cmd_first = 1.
REQ-014 axi_w_valid asserted in IDLE or RESP SHALL be ignored (axi_w_ready = 0).
REQ-015 err_sticky SHALL set on any SLVERR response and clear only on rst.

Reset
REQ-016 On rst high at posedge: state IDLE, beat counter 0, latched fields 0, err_sticky 0; all valid/ready outputs 0 combinationally except axi_aw_ready = 1 from the first cycle after rst deasserts.
REQ-017 rst mid-burst SHALL abandon the burst; no B response is issued for it.

Configuration
REQ-018 Macro AXI_WR_SEQ_LAST_CHECK_EN: when defined, axi_w_last mismatch (1 before final beat, or 0 on final beat) SHALL force SLVERR; beat count still governed by len. When undefined, axi_w_last is ignored and response depends only on REQ-009/010.

Structure
REQ-019 Package axi2ahb_pkg SHALL hold: state enum, burst-type enum, BRESP constants (OKAY, SLVERR), and a size-to-bytes function.
REQ-020 Next-address arithmetic (REQ-008) SHALL be a sub-module axi_wr_addr_gen (combinational: addr, size, burst -> next addr).

Verification
REQ-021 INCR addr 0x1003, size 2, len 3, DW 64 -> cmd_addr 0x1003, 0x1004, 0x1008, 0x100C; BRESP 00.
REQ-022 FIXED addr 0x2000, size 3, len 2 -> three beats all at 0x2000; cmd_first only on first.
REQ-023 INCR addr 0xFFFFFFF8, size 3, len 1 -> 0xFFFFFFF8 then 0x00000000; BRESP 00.
REQ-024 cmd_ready low 5 cycles mid-burst -> axi_w_ready low, no beat lost/duplicated, address held.
REQ-025 size 4 with DW 64 -> cmd_size 3, BRESP 10, err_sticky 1; with AXI_WR_SEQ_LAST_CHECK_EN, WLAST on beat 0 of len 2 -> BRESP 10.
REQ-026 rst after beat 1 of len 3 -> no BVALID; next burst len 0 completes with BRESP 00.

Source files
------------

// File: rtl/axi2ahb_pkg.sv
// Shared types and constants for the AXI write-to-AHB beat sequencer.
package axi2ahb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BEAT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic int unsigned size_to_bytes(input logic [2:0] size);
    return 32'd1 << size;
  endfunction

endpackage

// File: rtl/axi_wr_addr_gen.sv
// Combinational next-beat address: aligned increment for INCR (and reserved
// types, which are treated as INCR), hold for FIXED; wraps modulo 2^AW.
module axi_wr_addr_gen
  import axi2ahb_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0] i_addr,
  input  logic [2:0]    i_size,
  input  logic [1:0]    i_burst,
  output logic [AW-1:0] o_next_addr
);

  logic [AW-1:0] w_step;

  always_comb begin
    w_step = AW'(size_to_bytes(i_size));
    if (burst_t'(i_burst) == BURST_FIXED)
      o_next_addr = i_addr;
    else
      o_next_addr = (i_addr & ~(w_step - AW'(1))) + w_step;
  end

endmodule

// File: rtl/axi_wr_beat_sequencer.sv
// AXI write-channel to per-beat command sequencer, one burst outstanding.
// Optional macro AXI_WR_SEQ_LAST_CHECK_EN: WLAST mismatch forces SLVERR.
module axi_wr_beat_sequencer
  import axi2ahb_pkg::*;
#(
  parameter int TIDW = 1,
  parameter int AW   = 32,
  parameter int DW   = 64,
  parameter int LENW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [TIDW-1:0] axi_aw_id,
  input  logic [AW-1:0]   axi_aw_addr,
  input  logic [LENW-1:0] axi_aw_len,
  input  logic [2:0]      axi_aw_size,
  input  logic [1:0]      axi_aw_burst,
  input  logic            axi_aw_valid,
  output logic            axi_aw_ready,
  input  logic [DW-1:0]   axi_w_data,
  input  logic [DW/8-1:0] axi_w_strb,
  input  logic            axi_w_last,
  input  logic            axi_w_valid,
  output logic            axi_w_ready,
  output logic [AW-1:0]   cmd_addr,
  output logic [2:0]      cmd_size,
  output logic [DW-1:0]   cmd_data,
  output logic [DW/8-1:0] cmd_strb,
  output logic            cmd_first,
  output logic            cmd_valid,
  input  logic            cmd_ready,
  output logic [TIDW-1:0] axi_b_id,
  output logic [1:0]      axi_b_resp,
  output logic            axi_b_valid,
  input  logic            axi_b_ready,
  output logic            err_sticky
);

  localparam logic [2:0] MAX_SIZE = 3'($clog2(DW/8));

  state_t          r_state;
  logic [TIDW-1:0] r_id;
  logic [AW-1:0]   r_addr;
  logic [LENW-1:0] r_len;
  logic [LENW-1:0] r_cnt;
  logic [2:0]      r_size;
  logic [1:0]      r_burst;
  logic            r_err;
  logic            r_err_sticky;

  logic          w_in_beat;
  logic          w_aw_hs;
  logic          w_beat_hs;
  logic          w_final_beat;
  logic          w_last_err;
  logic          w_aw_err;
  logic [AW-1:0] w_next_addr;

  assign w_in_beat    = (r_state == ST_BEAT) && !rst;
  assign w_aw_hs      = (r_state == ST_IDLE) && axi_aw_valid;
  assign w_beat_hs    = w_in_beat && axi_w_valid && cmd_ready;
  assign w_final_beat = (r_cnt == r_len);
  assign w_aw_err     = axi_aw_burst[1] || (axi_aw_size > MAX_SIZE);

`ifdef AXI_WR_SEQ_LAST_CHECK_EN
  assign w_last_err = w_beat_hs && (axi_w_last != w_final_beat);
`else
  logic w_unused_last;
  assign w_unused_last = axi_w_last;
  assign w_last_err    = 1'b0;
`endif

  axi_wr_addr_gen #(.AW(AW)) u_addr_gen (
    .i_addr      (r_addr),
    .i_size      (r_size),
    .i_burst     (r_burst),
    .o_next_addr (w_next_addr)
  );

  // Size is stored already clamped so cmd_size and address stepping agree.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_id         <= '0;
      r_addr       <= '0;
      r_len        <= '0;
      r_cnt        <= '0;
      r_size       <= '0;
      r_burst      <= '0;
      r_err        <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_aw_hs) begin
            r_id    <= axi_aw_id;
            r_addr  <= axi_aw_addr;
            r_len   <= axi_aw_len;
            r_size  <= (axi_aw_size > MAX_SIZE) ? MAX_SIZE : axi_aw_size;
            r_burst <= axi_aw_burst;
            r_cnt   <= '0;
            r_err   <= w_aw_err;
            r_state <= ST_BEAT;
          end
        end
        ST_BEAT: begin
          if (w_beat_hs) begin
            r_addr <= w_next_addr;
            r_cnt  <= r_cnt + LENW'(1);
            r_err  <= r_err | w_last_err;
            if (w_final_beat) begin
              r_err_sticky <= r_err_sticky | r_err | w_last_err;
              r_state      <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (axi_b_ready) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign axi_aw_ready = (r_state == ST_IDLE) && !rst;
  assign axi_w_ready  = w_in_beat && cmd_ready;
  assign cmd_valid    = w_in_beat && axi_w_valid;
  assign cmd_addr     = r_addr;
  assign cmd_size     = r_size;
  assign cmd_data     = axi_w_data;
  assign cmd_strb     = axi_w_strb;
  assign cmd_first    = (r_cnt == '0);
  assign axi_b_valid  = (r_state == ST_RESP) && !rst;
  assign axi_b_id     = r_id;
  assign axi_b_resp   = r_err ? RESP_SLVERR : RESP_OKAY;
  assign err_sticky   = r_err_sticky;

endmodule

// File: tb/tb_axi_wr_beat_sequencer.sv
// Directed, table-driven bench for axi_wr_beat_sequencer (DW=64, AW=32).
module tb_axi_wr_beat_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:0]  axi_aw_id;
  logic [31:0] axi_aw_addr;
  logic [7:0]  axi_aw_len;
  logic [2:0]  axi_aw_size;
  logic [1:0]  axi_aw_burst;
  logic        axi_aw_valid;
  logic        axi_aw_ready;
  logic [63:0] axi_w_data;
  logic [7:0]  axi_w_strb;
  logic        axi_w_last;
  logic        axi_w_valid;
  logic        axi_w_ready;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [63:0] cmd_data;
  logic [7:0]  cmd_strb;
  logic        cmd_first;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [0:0]  axi_b_id;
  logic [1:0]  axi_b_resp;
  logic        axi_b_valid;
  logic        axi_b_ready;
  logic        err_sticky;

  int n_checks = 0;
  int n_pass   = 0;
  logic exp_sticky = 1'b0;

  always #5 clk = ~clk;

  axi_wr_beat_sequencer #(.TIDW(1), .AW(32), .DW(64), .LENW(8)) dut (
    .clk(clk), .rst(rst),
    .axi_aw_id(axi_aw_id), .axi_aw_addr(axi_aw_addr), .axi_aw_len(axi_aw_len),
    .axi_aw_size(axi_aw_size), .axi_aw_burst(axi_aw_burst),
    .axi_aw_valid(axi_aw_valid), .axi_aw_ready(axi_aw_ready),
    .axi_w_data(axi_w_data), .axi_w_strb(axi_w_strb), .axi_w_last(axi_w_last),
    .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_data(cmd_data),
    .cmd_strb(cmd_strb), .cmd_first(cmd_first), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .axi_b_id(axi_b_id), .axi_b_resp(axi_b_resp), .axi_b_valid(axi_b_valid),
    .axi_b_ready(axi_b_ready), .err_sticky(err_sticky)
  );

  typedef struct {
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [3:0][31:0] exp_addr;
    logic [1:0]       exp_resp;
    logic [2:0]       exp_size;
    int               stall_at;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic send_aw(input logic id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    @(negedge clk);
    axi_w_valid  = 1'b1;  // stray W data in IDLE must be ignored
    axi_aw_id    = id;
    axi_aw_addr  = addr;
    axi_aw_len   = len;
    axi_aw_size  = size;
    axi_aw_burst = burst;
    axi_aw_valid = 1'b1;
    #1;
    chk("aw_ready_idle", axi_aw_ready, 1'b1);
    chk("w_ready_idle", axi_w_ready, 1'b0);
    chk("cmd_valid_idle", cmd_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    axi_aw_valid = 1'b0;
  endtask

  // Called at a negedge; leaves the bench at the next negedge after the handshake.
  task automatic send_beat(input logic [31:0] ea, input logic first, input logic [2:0] es,
                           input logic last);
    logic [63:0] d;
    d = {$urandom, $urandom};
    axi_w_valid = 1'b1;
    axi_w_data  = d;
    axi_w_strb  = 8'($urandom);
    axi_w_last  = last;
    cmd_ready   = 1'b1;
    #1;
    chk("cmd_valid", cmd_valid, 1'b1);
    chk("w_ready", axi_w_ready, 1'b1);
    chk("cmd_addr", cmd_addr, ea);
    chk("cmd_first", cmd_first, first);
    chk("cmd_size", cmd_size, es);
    chk("cmd_data", cmd_data, d);
    chk("cmd_strb", cmd_strb, axi_w_strb);
    chk("aw_ready_busy", axi_aw_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_burst(input logic id, input vec_t v, input int bad_last);
    int t;
    send_aw(id, v.addr, v.len, v.size, v.burst);
    for (int b = 0; b <= int'(v.len); b++) begin
      if (b == v.stall_at) begin
        for (int s = 0; s < 5; s++) begin
          axi_w_valid = 1'b1;
          cmd_ready   = 1'b0;
          #1;
          chk("stall_w_ready", axi_w_ready, 1'b0);
          chk("stall_addr", cmd_addr, v.exp_addr[b]);
          chk("stall_no_b", axi_b_valid, 1'b0);
          @(posedge clk);
          @(negedge clk);
        end
      end
      send_beat(v.exp_addr[b], b == 0, v.exp_size, (b == int'(v.len)) ^ (b == bad_last));
    end
    cmd_ready = 1'b1;
    #1;
    chk("b_valid_on_time", axi_b_valid, 1'b1);
    t = 0;
    while (!axi_b_valid && t < 20) begin
      @(posedge clk); @(negedge clk); #1;
      t++;
    end
    chk("w_ready_resp", axi_w_ready, 1'b0);
    chk("aw_ready_resp", axi_aw_ready, 1'b0);
    chk("b_id", axi_b_id, id);
    chk("b_resp", axi_b_resp, v.exp_resp);
    axi_b_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    axi_b_ready = 1'b0;
    axi_w_valid = 1'b0;
    if (v.exp_resp == 2'b10) exp_sticky = 1'b1;
    #1;
    chk("b_valid_done", axi_b_valid, 1'b0);
    chk("aw_ready_back", axi_aw_ready, 1'b1);
    chk("err_sticky", err_sticky, exp_sticky);
  endtask

  initial begin
    vec_t vr;
    vecs[0] = '{32'h1003, 8'd3, 3'd2, 2'b01,
                {32'h100C, 32'h1008, 32'h1004, 32'h1003}, 2'b00, 3'd2, -1};
    vecs[1] = '{32'h2000, 8'd2, 3'd3, 2'b00,
                {32'h0, 32'h2000, 32'h2000, 32'h2000}, 2'b00, 3'd3, -1};
    vecs[2] = '{32'hFFFF_FFF8, 8'd1, 3'd3, 2'b01,
                {32'h0, 32'h0, 32'h0, 32'hFFFF_FFF8}, 2'b00, 3'd3, -1};
    vecs[3] = '{32'h1000, 8'd3, 3'd2, 2'b01,
                {32'h100C, 32'h1008, 32'h1004, 32'h1000}, 2'b00, 3'd2, 2};
    vecs[4] = '{32'h5006, 8'd1, 3'd1, 2'b01,
                {32'h0, 32'h0, 32'h5008, 32'h5006}, 2'b00, 3'd1, -1};
    vecs[5] = '{32'h3001, 8'd2, 3'd0, 2'b10,
                {32'h0, 32'h3003, 32'h3002, 32'h3001}, 2'b10, 3'd0, -1};
    vecs[6] = '{32'h4000, 8'd0, 3'd4, 2'b01,
                {32'h0, 32'h0, 32'h0, 32'h4000}, 2'b10, 3'd3, -1};

    rst = 1'b1;
    axi_aw_id = '0; axi_aw_addr = '0; axi_aw_len = '0; axi_aw_size = '0;
    axi_aw_burst = '0; axi_aw_valid = 1'b0; axi_w_data = '0; axi_w_strb = '0;
    axi_w_last = 1'b0; axi_w_valid = 1'b0; cmd_ready = 1'b0; axi_b_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_aw_ready", axi_aw_ready, 1'b0);
    chk("rst_b_valid", axi_b_valid, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_aw_ready", axi_aw_ready, 1'b1);
    chk("post_rst_sticky", err_sticky, 1'b0);

    for (int i = 0; i < 7; i++) run_burst(i[0], vecs[i], -1);

`ifdef AXI_WR_SEQ_LAST_CHECK_EN
    vr = '{32'h6000, 8'd2, 3'd3, 2'b01,
           {32'h0, 32'h6010, 32'h6008, 32'h6000}, 2'b10, 3'd3, -1};
    run_burst(1'b0, vr, 0);
`endif

    // Reset after beat 1 of a len-3 burst: burst abandoned, no B, sticky cleared.
    send_aw(1'b1, 32'h7000, 8'd3, 3'd2, 2'b01);
    send_beat(32'h7000, 1'b1, 3'd2, 1'b0);
    send_beat(32'h7004, 1'b0, 3'd2, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_cmd_valid", cmd_valid, 1'b0);
    chk("midrst_b_valid", axi_b_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_sticky = 1'b0;
    #1;
    chk("after_rst_aw_ready", axi_aw_ready, 1'b1);
    chk("after_rst_cmd_valid", cmd_valid, 1'b0);
    chk("after_rst_b_valid", axi_b_valid, 1'b0);
    chk("after_rst_sticky", err_sticky, 1'b0);
    repeat (3) begin
      @(posedge clk); @(negedge clk); #1;
      chk("no_stale_b", axi_b_valid, 1'b0);
    end
    vr = '{32'h8004, 8'd0, 3'd2, 2'b01,
           {32'h0, 32'h0, 32'h0, 32'h8004}, 2'b00, 3'd2, -1};
    run_burst(1'b0, vr, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
